// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if
// Groups the value-load handshake and the display pins of seg7_scan_ctrl.
//   value      [15:0]  value to display, held stable while load_req is high
//   load_req           level request to capture value at the next frame boundary
//   load_ack           one-cycle pulse confirming the capture
//   frame_done         one-cycle pulse per completed four-digit frame
//   an         [3:0]   active-low digit enables, an[0] = least significant nibble
//   seg7       [6:0]   active-low segments, bit 6 = a .. bit 0 = g
// master: the value producer / board side.  slave: the scan controller.
interface seg7_scan_ctrl_if;
    logic [15:0] value;
    logic        load_req;
    logic        load_ack;
    logic        frame_done;
    logic [3:0]  an;
    logic [6:0]  seg7;

    modport master (
        output value, load_req,
        input  load_ack, frame_done, an, seg7
    );

    modport slave (
        input  value, load_req,
        output load_ack, frame_done, an, seg7
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexes one hex-to-seven-segment decoder across four common-anode
// digits. A prescaler divides each digit slot into DIV cycles; the first cycle
// of every slot is a dark guard cycle. A shadow register holding the displayed
// value only updates at frame boundaries, so a frame never mixes two values.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   disp  seg7_scan_ctrl_if.slave (value/load handshake, an, seg7, frame_done)
// Parameters:
//   DIV       cycles per digit slot, >= 2
//   BLANK_LZ  1 = dark leading-zero digits 3..1 (digit 0 is always lit)
//
// state | meaning
// DIG0  | scanning digit 0 (least significant nibble)
// DIG1  | scanning digit 1
// DIG2  | scanning digit 2
// DIG3  | scanning digit 3; its last prescaler cycle is the frame boundary
module seg7_scan_ctrl #(
    parameter int DIV      = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic           clk,
    input logic           rst,
    seg7_scan_ctrl_if.slave disp
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

    digit_t        digit, digit_nxt;
    logic [PW-1:0] pcnt, pcnt_nxt;
    logic [15:0]   shadow, shadow_nxt;
    logic [3:0]    an_q, an_nxt;
    logic [6:0]    seg7_q, seg7_nxt;
    logic          ack_q, ack_nxt;
    logic          fd_q, fd_nxt;
    logic [3:0]    nibble;
    logic [3:0]    blank;
    logic [1:0]    didx;
    logic          wrap;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'h0: seg_decode = 7'b0000001;
            4'h1: seg_decode = 7'b1001111;
            4'h2: seg_decode = 7'b0010010;
            4'h3: seg_decode = 7'b0000110;
            4'h4: seg_decode = 7'b1001100;
            4'h5: seg_decode = 7'b0100100;
            4'h6: seg_decode = 7'b0100000;
            4'h7: seg_decode = 7'b0001111;
            4'h8: seg_decode = 7'b0000000;
            4'h9: seg_decode = 7'b0000100;
            4'hA: seg_decode = 7'b0001000;
            4'hB: seg_decode = 7'b1100000;
            4'hC: seg_decode = 7'b0110001;
            4'hD: seg_decode = 7'b1000010;
            4'hE: seg_decode = 7'b0110000;
            default: seg_decode = 7'b0111000;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            digit  <= DIG0;
            pcnt   <= '0;
            shadow <= '0;
            an_q   <= 4'b1111;
            seg7_q <= 7'b1111111;
            ack_q  <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            digit  <= digit_nxt;
            pcnt   <= pcnt_nxt;
            shadow <= shadow_nxt;
            an_q   <= an_nxt;
            seg7_q <= seg7_nxt;
            ack_q  <= ack_nxt;
            fd_q   <= fd_nxt;
        end
    end

    always_comb begin
        digit_nxt  = digit;
        pcnt_nxt   = pcnt + 1'b1;
        shadow_nxt = shadow;
        ack_nxt    = 1'b0;
        fd_nxt     = 1'b0;
        didx       = digit;
        wrap       = (pcnt == PMAX);

        // A digit is dark only when it and every more significant nibble are zero.
        blank[3] = BLANK_LZ && (shadow[15:12] == 4'h0);
        blank[2] = blank[3] && (shadow[11:8] == 4'h0);
        blank[1] = blank[2] && (shadow[7:4] == 4'h0);
        blank[0] = 1'b0;

        unique case (digit)
            DIG0: nibble = shadow[3:0];
            DIG1: nibble = shadow[7:4];
            DIG2: nibble = shadow[11:8];
            DIG3: nibble = shadow[15:12];
        endcase

        if (wrap) begin
            pcnt_nxt = '0;
            unique case (digit)
                DIG0: digit_nxt = DIG1;
                DIG1: digit_nxt = DIG2;
                DIG2: digit_nxt = DIG3;
                DIG3: begin
                    digit_nxt = DIG0;
                    fd_nxt    = 1'b1;
                    if (disp.load_req) begin
                        shadow_nxt = disp.value;
                        ack_nxt    = 1'b1;
                    end
                end
            endcase
        end

        // The guard cycle keeps anodes dark while segments settle on the new digit.
        seg7_nxt = blank[didx] ? 7'b1111111 : seg_decode(nibble);
        an_nxt   = 4'b1111;
        if ((pcnt != '0) && !blank[didx]) begin
            an_nxt[didx] = 1'b0;
        end
    end

    assign disp.an         = an_q;
    assign disp.seg7       = seg7_q;
    assign disp.load_ack   = ack_q;
    assign disp.frame_done = fd_q;
endmodule
